// File: rtl/fb_scan_reader.sv
// fb_scan_reader: framebuffer scan-out read initiator with credit-bounded reads; optional FB_DBUF_EN adds double-buffer bank select
module fb_scan_reader #(
  parameter int H_ACTIVE = 128,
  parameter int V_ACTIVE = 64,
  parameter int STRIDE = 128,
  parameter int BASE0 = 0,
`ifdef FB_DBUF_EN
  parameter int BASE1 = 8192,
`endif
  parameter int MAX_OUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        frame_done,
  output logic        addr_out_wen,
  output logic [15:0] addr_out_wd,
  input  logic        addr_out_full,
  output logic        data_in_ren,
  input  logic [15:0] data_in_rd,
  input  logic        data_in_empty,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic        pix_sol,
  output logic        pix_eol,
  output logic        pix_sof,
  output logic        pix_eof
`ifdef FB_DBUF_EN
  ,
  output logic        front_bank
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [15:0] H_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] V_LAST = 16'(V_ACTIVE - 1);
  localparam logic [3:0] CRED_MAX = 4'(MAX_OUT);
  state_t state;
  logic [15:0] ix, iy, ox, oy, row_base, base;
  logic [3:0] credits;
  logic issue_done, issue, load, accept;
`ifdef FB_DBUF_EN
  assign base = front_bank ? 16'(BASE1) : 16'(BASE0);
`else
  assign base = 16'(BASE0);
`endif
  // Handshake decisions: issue gating, show-ahead pop, frame completion
  always_comb begin
    accept = pix_valid & pix_ready;
    load = (state == RUN) & ~data_in_empty & (~pix_valid | pix_ready);
    data_in_ren = load | ((state == DRAIN) & ~data_in_empty & (credits != 4'd0));
    issue = (state == RUN) & ~abort & ~issue_done & ~addr_out_full & (credits < CRED_MAX);
    frame_done = (state == RUN) & ~abort & accept & pix_eof;
    busy = state != IDLE;
  end
  // Scan FSM with issue counters, credit tracking and the pixel output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ix <= '0;
      iy <= '0;
      ox <= '0;
      oy <= '0;
      row_base <= '0;
      issue_done <= 1'b0;
      credits <= '0;
      addr_out_wen <= 1'b0;
      addr_out_wd <= '0;
      pix_valid <= 1'b0;
      pix_data <= '0;
      pix_sol <= 1'b0;
      pix_eol <= 1'b0;
      pix_sof <= 1'b0;
      pix_eof <= 1'b0;
`ifdef FB_DBUF_EN
      front_bank <= 1'b0;
`endif
    end else begin
      addr_out_wen <= issue;
      credits <= credits + {3'b0, issue} - {3'b0, data_in_ren};
      if (issue) begin
        addr_out_wd <= row_base + ix;
        ix <= (ix == H_LAST) ? 16'd0 : ix + 16'd1;
        iy <= (ix == H_LAST) ? iy + 16'd1 : iy;
        row_base <= (ix == H_LAST) ? row_base + 16'(STRIDE) : row_base;
        issue_done <= (ix == H_LAST) && (iy == V_LAST);
      end
      if (load) begin
        pix_valid <= 1'b1;
        pix_data <= data_in_rd;
        pix_sol <= ox == 16'd0;
        pix_eol <= ox == H_LAST;
        pix_sof <= (ox == 16'd0) && (oy == 16'd0);
        pix_eof <= (ox == H_LAST) && (oy == V_LAST);
        ox <= (ox == H_LAST) ? 16'd0 : ox + 16'd1;
        oy <= (ox == H_LAST) ? oy + 16'd1 : oy;
      end else if (accept) begin
        pix_valid <= 1'b0;
      end
      case (state)
        IDLE: if (start && !abort) begin
          state <= RUN;
          ix <= '0;
          iy <= '0;
          ox <= '0;
          oy <= '0;
          row_base <= base;
          issue_done <= 1'b0;
        end
        RUN: if (abort) begin
          // Anything sitting in the pixel register is discarded; markers are quiet while draining
          state <= DRAIN;
          pix_valid <= 1'b0;
          pix_sol <= 1'b0;
          pix_eol <= 1'b0;
          pix_sof <= 1'b0;
          pix_eof <= 1'b0;
        end else if (frame_done) begin
          state <= IDLE;
`ifdef FB_DBUF_EN
          front_bank <= ~front_bank;
`endif
        end
        DRAIN: if (credits == 4'd0 && !pix_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_scan_reader.sv
// tb_fb_scan_reader: randomized directed bench for fb_scan_reader with a latency-2 RAM FIFO model and a frame scoreboard
module tb_fb_scan_reader;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, addr_out_full = 0, data_in_empty = 1, pix_ready = 0;
  logic [15:0] data_in_rd = 0;
  logic busy, frame_done, addr_out_wen, data_in_ren, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof;
  logic [15:0] addr_out_wd, pix_data;
`ifdef FB_DBUF_EN
  logic front_bank;
`endif
  fb_scan_reader #(
    .H_ACTIVE(4), .V_ACTIVE(2), .STRIDE(8), .BASE0(16),
`ifdef FB_DBUF_EN
    .BASE1(48),
`endif
    .MAX_OUT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .frame_done(frame_done),
    .addr_out_wen(addr_out_wen), .addr_out_wd(addr_out_wd), .addr_out_full(addr_out_full),
    .data_in_ren(data_in_ren), .data_in_rd(data_in_rd), .data_in_empty(data_in_empty),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_eof(pix_eof)
`ifdef FB_DBUF_EN
    , .front_bank(front_bank)
`endif
  );
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int issued = 0, popped = 0, pix_idx = 0, fd_cnt = 0;
  int iss_base = 0, pix_base = 0, fd_base = 0, cyc_n = 0;
  bit no_issue = 0, draining = 0, hold_empty = 0, bank_m = 0;
  logic [15:0] salt, fb_base = 16'd16;
  logic s_wen = 0, s_ren = 0;
  logic [15:0] s_wd = 0;
  logic [15:0] dq[$];
  logic [15:0] pa[$];
  int pt[$];
  logic [19:0] snap;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return 16'(a * 16'd251) ^ salt;
  endfunction

  // Pixel k of a frame lives at base + row*STRIDE + column
  function automatic logic [15:0] exp_addr(input int k);
    return 16'(int'(fb_base) + (k / 4) * 8 + k % 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Scoreboard: sample handshakes mid-cycle, check addresses, pixels, drain quietness and credit bound
  always @(negedge clk) begin
    if (!rst_n) begin
      issued = 0;
      popped = 0;
      s_wen = 0;
      s_ren = 0;
    end else begin
      s_wen = addr_out_wen;
      s_wd = addr_out_wd;
      s_ren = data_in_ren;
      if (addr_out_wen) begin
        if (no_issue || issued - iss_base >= 8) chk("addr_extra", 1, 0);
        else chk("addr", addr_out_wd, exp_addr(issued - iss_base));
        issued++;
      end
      if (data_in_ren) popped++;
      if (draining) chk("drain_valid", pix_valid, 0);
      else if (pix_valid && pix_ready) begin
        int k;
        k = pix_idx - pix_base;
        chk("pix", {pix_sol, pix_eol, pix_sof, pix_eof, pix_data},
            {k % 4 == 0, k % 4 == 3, k == 0, k == 7, mem_val(exp_addr(k))});
        pix_idx++;
      end
      if (frame_done) fd_cnt++;
      if (busy) chk("credits", (issued - popped) <= 2, 1);
    end
  end

  // RAM model: address FIFO feeding a 2-cycle read pipe into a show-ahead data FIFO
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      dq.delete();
      pa.delete();
      pt.delete();
    end else begin
      cyc_n++;
      if (s_ren && dq.size() > 0) void'(dq.pop_front());
      if (s_wen) begin
        pa.push_back(s_wd);
        pt.push_back(cyc_n + 2);
      end
      while (pt.size() > 0 && pt[0] <= cyc_n) begin
        dq.push_back(mem_val(pa.pop_front()));
        void'(pt.pop_front());
      end
    end
    data_in_empty = hold_empty || dq.size() == 0;
    data_in_rd = dq.size() > 0 ? dq[0] : 16'h0;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
`ifdef FB_DBUF_EN
    fb_base = bank_m ? 16'd48 : 16'd16;
`else
    fb_base = 16'd16;
`endif
    iss_base = issued;
    pix_base = pix_idx;
    fd_base = fd_cnt;
    no_issue = 0;
    start = 1;
    cyc();
    start = 0;
    chk("busy_on_start", busy, 1);
  endtask

  task automatic finish_frame(input string tag, input bit rand_ready);
    int n = 0;
    while (busy && n < 400) begin
      if (rand_ready) pix_ready = 1'($urandom);
      cyc();
      n++;
    end
    pix_ready = 1;
    chk({tag, "_timeout"}, busy, 0);
    chk({tag, "_done"}, fd_cnt - fd_base, 1);
    chk({tag, "_pixels"}, pix_idx - pix_base, 8);
    chk({tag, "_issued"}, issued - iss_base, 8);
    bank_m = ~bank_m;
`ifdef FB_DBUF_EN
    chk({tag, "_bank"}, front_bank, bank_m);
`endif
  endtask

  task automatic wait_pix(input int cnt);
    int n = 0;
    while (!(pix_idx - pix_base >= cnt && pix_valid) && n < 200) begin
      cyc();
      n++;
    end
    chk("wait_pix_timeout", n < 200, 1);
  endtask

  task automatic wait_issue(input int cnt);
    int n = 0;
    while (issued - iss_base < cnt && n < 200) begin
      cyc();
      n++;
    end
    chk("wait_issue_timeout", n < 200, 1);
  endtask

  initial begin
    salt = 16'($urandom);
    repeat (2) cyc();
    chk("reset_outs", {busy, frame_done, addr_out_wen, data_in_ren, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof}, 0);
    chk("reset_wd_data", {addr_out_wd, pix_data}, 0);
    rst_n = 1;
    pix_ready = 1;
    cyc();
    start_frame();
    finish_frame("f1", 0);
    hold_empty = 1;
    start_frame();
    repeat (10) cyc();
    chk("hold_issued", issued - iss_base, 2);
    chk("hold_no_pop", data_in_ren, 0);
    hold_empty = 0;
    finish_frame("hold", 0);
    start_frame();
    wait_pix(2);
    pix_ready = 0;
    snap = {pix_sol, pix_eol, pix_sof, pix_eof, pix_data};
    repeat (10) begin
      @(negedge clk);
      chk("stall_hold", {pix_valid, data_in_ren, pix_sol, pix_eol, pix_sof, pix_eof, pix_data}, {2'b10, snap});
      cyc();
    end
    pix_ready = 1;
    finish_frame("stall", 1);
    start_frame();
    wait_issue(2);
    addr_out_full = 1;
    cyc();
    repeat (5) begin
      @(negedge clk);
      chk("full_no_wen", addr_out_wen, 0);
      cyc();
    end
    addr_out_full = 0;
    finish_frame("full", 0);
    start_frame();
    wait_pix(3);
    abort = 1;
    cyc();
    abort = 0;
    no_issue = 1;
    draining = 1;
    for (int n = 0; n < 200 && busy; n++) cyc();
    draining = 0;
    chk("abort_timeout", busy, 0);
    chk("abort_no_done", fd_cnt - fd_base, 0);
    chk("abort_drained", issued - popped, 0);
    chk("abort_pix_valid", pix_valid, 0);
    start_frame();
    finish_frame("restart", 1);
    start_frame();
    repeat (5) cyc();
    rst_n = 0;
    #1;
    chk("midrst_outs", {busy, frame_done, addr_out_wen, data_in_ren, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof}, 0);
    chk("midrst_wd_data", {addr_out_wd, pix_data}, 0);
`ifdef FB_DBUF_EN
    chk("midrst_bank", front_bank, 0);
`endif
    bank_m = 0;
    repeat (2) cyc();
    rst_n = 1;
    cyc();
    start_frame();
    finish_frame("post_rst", 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
